// File: rtl/demux_deserializer_8_pkg.sv
// Shared constants for the 8:1 serializer / 1:8 deserializer pair.
// The matching serializer uses the same widths and slot numbering.
package demux_deserializer_8_pkg;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] SLOT_FIRST = 3'd0;
  localparam logic [SEL_W-1:0] SLOT_LAST  = 3'd7;
endpackage

// File: rtl/demux_deserializer_8_if.sv
// Serial input, framing and parallel output handshake of the deserializer.
// valid/ready: a word transfers on every rising edge where out_valid and out_ready are both 1.
interface demux_deserializer_8_if;
  import demux_deserializer_8_pkg::*;

  logic              serial_in;
  logic              in_valid;
  logic              frame_sync;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [SEL_W-1:0]  slot;
  logic              overrun;
  logic              overrun_clr;

  modport master (
    output serial_in, in_valid, frame_sync, out_ready, overrun_clr,
    input  out_data, out_valid, slot, overrun
  );

  modport slave (
    input  serial_in, in_valid, frame_sync, out_ready, overrun_clr,
    output out_data, out_valid, slot, overrun
  );
endinterface

// File: rtl/demux_deserializer_8_demux.sv
// Combinational 1-to-8 demultiplexer: d is routed to y[sel] when en is high.
// Each output is one minterm of sel, the same decode as a 3-to-8 decoder.
module demux_1_8
  import demux_deserializer_8_pkg::*;
(
  input  logic [SEL_W-1:0]  sel,
  input  logic              en,
  input  logic              d,
  output logic [DATA_W-1:0] y
);
  always_comb begin
    y = '0;
    for (int i = 0; i < DATA_W; i++) begin
      y[i] = en && d && (sel == SEL_W'(i));
    end
  end
endmodule

// File: rtl/demux_deserializer_8.sv
// Serial-to-parallel receiver: LSB-first bits are steered into a shadow
// register by slot, and completed words move to a valid/ready output register.
module demux_deserializer_8
  import demux_deserializer_8_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  demux_deserializer_8_if.slave bus
);
  logic [SEL_W-1:0]  slot_q, slot_d, wr_sel;
  logic [DATA_W-1:0] shadow_q, wr_en, word;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, overrun_q;
  logic              complete, load, drop, consume;

  // frame_sync realigns before the write, so a coincident bit lands in slot 0.
  always_comb begin
    wr_sel   = bus.frame_sync ? SLOT_FIRST : slot_q;
    slot_d   = slot_q;
    if (bus.frame_sync) begin
      slot_d = bus.in_valid ? SEL_W'(SLOT_FIRST + 1) : SLOT_FIRST;
    end else if (bus.in_valid) begin
      slot_d = slot_q + SEL_W'(1);
    end
    complete = bus.in_valid && !bus.frame_sync && (slot_q == SLOT_LAST);
    word     = {bus.serial_in, shadow_q[DATA_W-2:0]};
    consume  = out_valid_q && bus.out_ready;
    load     = complete && (!out_valid_q || bus.out_ready);
    drop     = complete && out_valid_q && !bus.out_ready;
  end

  demux_1_8 u_demux (
    .sel (wr_sel),
    .en  (bus.in_valid),
    .d   (1'b1),
    .y   (wr_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q   <= SLOT_FIRST;
      shadow_q <= '0;
    end else begin
      slot_q <= slot_d;
      for (int i = 0; i < DATA_W; i++) begin
        if (wr_en[i]) shadow_q[i] <= bus.serial_in;
      end
    end
  end

  // A completion wins over a plain consume; overrun set wins over its clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (load) begin
        out_data_q  <= word;
        out_valid_q <= 1'b1;
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (bus.overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.slot      = slot_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_demux_deserializer_8.sv
// Directed bench for demux_deserializer_8: streaming, overrun, simultaneous
// handshake, frame_sync realign, gapped input and asynchronous reset.
module tb_demux_deserializer_8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  demux_deserializer_8_if bus ();

  demux_deserializer_8 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, outputs sampled 1ns after the rising edge
  task automatic drive_bit(input logic b, input logic v, input logic fs);
    @(negedge clk);
    bus.serial_in  = b;
    bus.in_valid   = v;
    bus.frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.frame_sync = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) drive_bit(w[i], 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0]  pat;
    logic [15:0] vmask;
    logic [2:0]  exp_slot;
    int          j;

    bus.serial_in   = 1'b0;
    bus.in_valid    = 1'b0;
    bus.frame_sync  = 1'b0;
    bus.out_ready   = 1'b1;
    bus.overrun_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_slot", 32'(bus.slot), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'h00);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Stream 1,0,1,1,0,0,1,0 LSB-first -> 8'h4D
    pat = 8'h4D;
    for (int i = 0; i < 3; i++) drive_bit(pat[i], 1'b1, 1'b0);
    check("s1_slot3", 32'(bus.slot), 32'd3);
    check("s1_valid_early", 32'(bus.out_valid), 32'd0);
    for (int i = 3; i < 8; i++) drive_bit(pat[i], 1'b1, 1'b0);
    check("s1_valid", 32'(bus.out_valid), 32'd1);
    check("s1_data", 32'(bus.out_data), 32'h4D);
    check("s1_slot0", 32'(bus.slot), 32'd0);
    idle_cycle();
    check("s1_consumed", 32'(bus.out_valid), 32'd0);
    check("s1_data_hold", 32'(bus.out_data), 32'h4D);

    // Overrun: A5 held, 3C dropped
    bus.out_ready = 1'b0;
    send_word(8'hA5);
    check("s2_valid", 32'(bus.out_valid), 32'd1);
    check("s2_data", 32'(bus.out_data), 32'hA5);
    check("s2_no_ovr", 32'(bus.overrun), 32'd0);
    send_word(8'h3C);
    check("s2_data_kept", 32'(bus.out_data), 32'hA5);
    check("s2_overrun", 32'(bus.overrun), 32'd1);
    check("s2_valid_kept", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.overrun_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.overrun_clr = 1'b0;
    check("s2_ovr_clr", 32'(bus.overrun), 32'd0);
    check("s2_valid_after_clr", 32'(bus.out_valid), 32'd1);

    // Consume A5 on the same edge 0F completes
    pat = 8'h0F;
    for (int i = 0; i < 7; i++) drive_bit(pat[i], 1'b1, 1'b0);
    check("s3_data_pre", 32'(bus.out_data), 32'hA5);
    bus.out_ready = 1'b1;
    drive_bit(pat[7], 1'b1, 1'b0);
    check("s3_data", 32'(bus.out_data), 32'h0F);
    check("s3_valid", 32'(bus.out_valid), 32'd1);
    check("s3_overrun", 32'(bus.overrun), 32'd0);
    idle_cycle();
    check("s3_consumed", 32'(bus.out_valid), 32'd0);

    // frame_sync realign after 5 bits, then pattern 81
    for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b1, 1'b0);
    check("s4_slot5", 32'(bus.slot), 32'd5);
    pat = 8'h81;
    drive_bit(pat[0], 1'b1, 1'b1);
    check("s4_slot_sync", 32'(bus.slot), 32'd1);
    check("s4_no_word", 32'(bus.out_valid), 32'd0);
    for (int i = 1; i < 8; i++) drive_bit(pat[i], 1'b1, 1'b0);
    check("s4_data", 32'(bus.out_data), 32'h81);
    check("s4_valid", 32'(bus.out_valid), 32'd1);
    idle_cycle();

    // Gapped in_valid carrying C3
    bus.out_ready = 1'b0;
    pat      = 8'hC3;
    vmask    = 16'h5359;
    exp_slot = 3'd0;
    j        = 0;
    for (int i = 0; i < 16; i++) begin
      if (vmask[i]) begin
        drive_bit(pat[j], 1'b1, 1'b0);
        j++;
        exp_slot = exp_slot + 3'd1;
      end else begin
        drive_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      check("s5_slot", 32'(bus.slot), 32'(exp_slot));
    end
    check("s5_data", 32'(bus.out_data), 32'hC3);
    check("s5_valid", 32'(bus.out_valid), 32'd1);

    // Asynchronous reset mid-word with a held word
    bus.out_ready = 1'b1;
    idle_cycle();
    bus.out_ready = 1'b0;
    send_word(8'h5A);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b1, 1'b0);
    check("s6_slot4", 32'(bus.slot), 32'd4);
    check("s6_valid_pre", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_slot", 32'(bus.slot), 32'd0);
    check("s6_async_valid", 32'(bus.out_valid), 32'd0);
    check("s6_async_data", 32'(bus.out_data), 32'h00);
    check("s6_async_ovr", 32'(bus.overrun), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    bus.out_ready = 1'b1;
    send_word(8'h96);
    check("s6_after_data", 32'(bus.out_data), 32'h96);
    check("s6_after_valid", 32'(bus.out_valid), 32'd1);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux_deserializer_8.md
# demux_deserializer_8

Serial-to-parallel receiver that converts a 1-bit stream into 8-bit words. A 3-bit slot counter drives a 1-to-8 demultiplexer that steers each accepted bit into its slot of a shadow register. Completed words move into an output holding register with a valid/ready handshake. It is the receive end of the mux-based 8:1 serializer path in the lab datapath: slot 0 is sent first, so words arrive LSB-first.

## Interface
- Parameters:
  - DATA_W, 8, word width; fixed at 8 in this revision.
  - SEL_W, 3, slot counter width; equals log2(DATA_W).
- Ports:
  - clk, input, 1, single clock; all state updates on the rising edge.
  - reset, input, 1, asynchronous, active-high; clears all state immediately.
  - serial_in, input, 1, data bit.
  - in_valid, input, 1, serial_in is accepted on this edge; there is no input back-pressure.
  - frame_sync, input, 1, synchronous realign: discard the partial word and restart at slot 0.
  - out_data, output, 8, completed word; bit k is the k-th bit received in the frame.
  - out_valid, output, 1, out_data holds an unconsumed word.
  - out_ready, input, 1, consumer takes out_data on an edge where out_valid=1 and out_ready=1.
  - slot, output, 3, current slot counter, meaning the slot the next bit will be written to.
  - overrun, output, 1, sticky: a completed word was dropped.
  - overrun_clr, input, 1, synchronous clear of overrun.

## Operation
- Reset values: slot=0, shadow=0, out_data=0, out_valid=0, overrun=0.
- Accept: in_valid=1 at an edge writes serial_in into shadow[slot] through the demux, then slot increments. Slot wraps from 7 to 0.
- Completion: an accept with slot=7 completes a word, formed as {serial_in, shadow[6:0]}.
  - If out_valid=0, or out_valid=1 with out_ready=1 on the same edge: load out_data and set out_valid=1.
  - Otherwise (out_valid=1, out_ready=0): drop the new word, keep out_data unchanged, and set overrun=1.
- Consume: an edge with out_valid=1, out_ready=1 and no completion clears out_valid. out_data holds its last value.
- frame_sync=1: slot goes to 0 and the partial shadow contents are discarded.
  - If in_valid=1 on the same edge, that bit is written to slot 0 and slot becomes 1.
  - frame_sync does not affect out_valid, out_data or overrun.
  - An accept at slot=7 coinciding with frame_sync does not complete a word; frame_sync wins.
- overrun_clr=1 clears overrun. If an overrun event occurs on the same edge, overrun stays 1 (set has priority).
- Shadow bits are not cleared between words. out_data only ever reflects 8 bits accepted in the current frame.
- Reset asserted mid-word or with out_valid=1: everything returns to reset values asynchronously, and the partial or held word is lost.

## Timing
- Latency: the 8th bit is accepted at edge N; out_valid=1 and out_data are valid from just after edge N.
- Sustained throughput: one word per 8 clocks with in_valid held at 1, provided out_ready is asserted at least once per 8 cycles.
- All outputs are registered; there is no combinational path from any input to any output.
- out_data is stable while out_valid=1 and the word has not been consumed.
- reset deassertion is synchronised by the integrator. The first accepted edge after release writes slot 0.

## Structure
- Shared package holds DATA_W=8, SEL_W=3, and the slot constants SLOT_FIRST=3'd0 and SLOT_LAST=3'd7. The matching serializer uses the same package.
- One natural sub-module: demux_1_8, a combinational 1-to-8 demultiplexer with inputs sel[2:0], en and d, and output y[7:0]. It is built from the same minterm decoding as the 3-to-8 decoder, and its output gates the per-slot shadow write enables.
- The top level holds the slot counter, shadow register, output register, handshake logic and overrun flag.

## Test plan
- Reset, then stream bits 1,0,1,1,0,0,1,0 with in_valid=1 and out_ready=1 -> out_valid=1 one edge after the 8th bit, out_data=8'h4D, slot=0.
- Hold out_ready=0, send word 8'hA5, then a full second word 8'h3C -> out_data stays 8'hA5 and overrun=1. Pulse overrun_clr -> overrun=0.
- out_valid=1 (8'hA5) with out_ready=1 on the same edge the next word 8'h0F completes -> out_data=8'h0F, out_valid stays 1, overrun=0.
- Send 5 bits, assert frame_sync with in_valid=1 and serial_in=1, then 7 more bits of pattern 8'h81 -> slot=1 right after frame_sync, and the next word is 8'h81.
- in_valid toggled 1/0 irregularly across 16 cycles carrying 8'hC3 -> out_data=8'hC3; slot only advances on in_valid edges.
- Assert reset asynchronously mid-clock with slot=4 and out_valid=1 -> all outputs go to reset values immediately, before the next clk edge.
